// File: rtl/sram_access_seq.sv
// rtl/sram_access_seq.sv - registered CS/OE/WE access sequencer for 71V016 vector SRAMs
// Optional write protection against WR_ALLOW: define SRAM_ACCESS_SEQ_WPROT_EN.
module sram_access_seq #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STROBE_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST_BAR,
  input  logic              REQ,
  input  logic              WR,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WR_ALLOW,
  output logic              READY,
  output logic              DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] RDATA,
  output logic              RDATA_VALID,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_OUT,
  output logic              SRAM_DQ_OE,
  input  logic [DATA_W-1:0] SRAM_DQ_IN,
  output logic              CS_BAR_OUT,
  output logic              OE_BAR_OUT,
  output logic              WE_BAR_OUT
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYC - 1);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       wr_q, refused_q;
  logic       accept, refuse, wr_n, ref_n;
  logic       cs_d, oe_d, we_d, dq_oe_d, done_d, rvalid_d, err_d;

  assign READY  = (state == IDLE);
  assign accept = REQ && (state == IDLE);

`ifdef SRAM_ACCESS_SEQ_WPROT_EN
  assign refuse = WR && !WR_ALLOW;
`else
  logic unused_wr_allow;
  assign unused_wr_allow = WR_ALLOW;
  assign refuse          = 1'b0;
`endif

  // Attributes of the access that will be in flight after this edge
  assign wr_n  = accept ? WR     : wr_q;
  assign ref_n = accept ? refuse : refused_q;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cs_d     = 1'b1;
    oe_d     = 1'b1;
    we_d     = 1'b1;
    dq_oe_d  = 1'b0;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    err_d    = 1'b0;

    unique case (state)
      IDLE:   if (REQ) state_d = SETUP;
      SETUP:  begin
        if (refused_q) begin
          state_d = IDLE;
        end else begin
          state_d = STROBE;
          cnt_d   = CNT_LOAD;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) state_d = HOLD;
        else             cnt_d   = cnt - 4'd1;
      end
      HOLD:   state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so the pins come straight off flops
    unique case (state_d)
      SETUP: begin
        if (ref_n) begin
          err_d = 1'b1;
        end else begin
          cs_d = 1'b0;
          if (wr_n) dq_oe_d = 1'b1;
          else      oe_d    = 1'b0;
        end
      end
      STROBE: begin
        cs_d = 1'b0;
        if (wr_n) begin
          we_d    = 1'b0;
          dq_oe_d = 1'b1;
        end else begin
          oe_d = 1'b0;
        end
      end
      HOLD: begin
        done_d   = 1'b1;
        dq_oe_d  = wr_n;
        rvalid_d = !wr_n;
      end
      IDLE: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      refused_q   <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_OUT <= '0;
      RDATA       <= '0;
      CS_BAR_OUT  <= 1'b1;
      OE_BAR_OUT  <= 1'b1;
      WE_BAR_OUT  <= 1'b1;
      SRAM_DQ_OE  <= 1'b0;
      DONE        <= 1'b0;
      RDATA_VALID <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      CS_BAR_OUT  <= cs_d;
      OE_BAR_OUT  <= oe_d;
      WE_BAR_OUT  <= we_d;
      SRAM_DQ_OE  <= dq_oe_d;
      DONE        <= done_d;
      RDATA_VALID <= rvalid_d;
      ERR         <= err_d;
      if (accept) begin
        wr_q        <= WR;
        refused_q   <= refuse;
        SRAM_ADDR   <= ADDR;
        SRAM_DQ_OUT <= WDATA;
      end
      if (state == STROBE && cnt == 4'd0 && !wr_q) RDATA <= SRAM_DQ_IN;
    end
  end

endmodule
